// File: rtl/router_mesh.sv
// router_mesh: input-buffered, single-flit-packet mesh router with XY routing,
// one ingress FIFO per port and a registered egress stage per port, each egress
// stage fed by a round-robin arbiter over all inputs.
module router_mesh #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_WIDTH = 128,
  parameter int COORD_W    = 4,
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              arst,
  input  logic [NUM_PORTS:0]                ing_val,
  input  logic [(NUM_PORTS+1)*PORT_WIDTH-1:0] ing_dat,
  output logic [NUM_PORTS:0]                ing_rdy,
  output logic [NUM_PORTS:0]                egr_val,
  output logic [(NUM_PORTS+1)*PORT_WIDTH-1:0] egr_dat,
  input  logic [NUM_PORTS:0]                egr_rdy,
  output logic                              drop_err
);
  localparam int NP = NUM_PORTS + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(NP);
  localparam logic [2:0]  MAX_PORT = 3'(NUM_PORTS);
  localparam logic [AW:0] DEPTH    = (AW+1)'(FIFO_DEPTH);

  logic [PORT_WIDTH-1:0] head [NP];
  logic [2:0]            route [NP];
  logic [NP-1:0]         not_empty;
  logic [NP-1:0]         drop;
  logic [NP-1:0]         pop;
  logic [NP-1:0]         gnt_mat [NP];

  genvar gi, gj;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_in
      logic [PORT_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]         wr_ptr;
      logic [AW-1:0]         rd_ptr;
      logic [AW:0]           count;
      logic                  push;
      logic [PORT_WIDTH-1:0] hd;
      logic [COORD_W-1:0]    dx;
      logic [COORD_W-1:0]    dy;
      logic [2:0]            rt;

      // Ready comes from the occupancy register only, so a pop never frees a
      // slot within the same cycle.
      assign ing_rdy[gi]   = (count != DEPTH);
      assign push          = ing_val[gi] & ing_rdy[gi];
      assign not_empty[gi] = (count != '0);
      assign hd            = mem[rd_ptr];
      assign head[gi]      = hd;
      assign dx            = hd[PORT_WIDTH-1 -: COORD_W];
      assign dy            = hd[PORT_WIDTH-1-COORD_W -: COORD_W];
      assign route[gi]     = rt;
      // A head that needs a port this node does not have is discarded at once.
      assign drop[gi]      = not_empty[gi] && (rt > MAX_PORT);

      // Storage array; the head is read combinationally so a flit can leave
      // in the cycle right after it was accepted.
      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ing_dat[gi*PORT_WIDTH +: PORT_WIDTH];
      end

      // FIFO pointers and occupancy.
      always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push)    wr_ptr <= wr_ptr + 1'b1;
          if (pop[gi]) rd_ptr <= rd_ptr + 1'b1;
          if (push && !pop[gi])      count <= count + 1'b1;
          else if (!push && pop[gi]) count <= count - 1'b1;
        end
      end

      // Dimension-ordered routing: resolve X first, then Y, else local NI.
      always_comb begin
        rt = 3'd0;
        if (dx > COORD_W'(X_COORD))      rt = 3'd1;
        else if (dx < COORD_W'(X_COORD)) rt = 3'd2;
        else if (dy > COORD_W'(Y_COORD)) rt = 3'd3;
        else if (dy < COORD_W'(Y_COORD)) rt = 3'd4;
      end
    end

    for (gi = 0; gi < NP; gi++) begin : g_out
      logic [RW-1:0]         rr;
      logic [NP-1:0]         req;
      logic                  found;
      logic                  grant;
      logic                  can_load;
      logic [RW-1:0]         sel;
      logic [RW:0]           idx;
      logic                  out_val;
      logic [PORT_WIDTH-1:0] out_dat;

      for (gj = 0; gj < NP; gj++) begin : g_req
        assign req[gj] = not_empty[gj] && (route[gj] == 3'(gi));
      end

      // Round-robin search: scan offsets high to low so the lowest offset
      // from rr (the first requester at or after rr, wrapping) wins.
      always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = NP - 1; k >= 0; k--) begin
          idx = {1'b0, rr} + (RW+1)'(k);
          if (idx >= (RW+1)'(NP)) idx = idx - (RW+1)'(NP);
          if (req[idx[RW-1:0]]) begin
            found = 1'b1;
            sel   = idx[RW-1:0];
          end
        end
      end

      assign can_load    = !out_val || egr_rdy[gi];
      assign grant       = found && can_load;
      assign gnt_mat[gi] = grant ? (NP'(1) << sel) : '0;
      assign egr_val[gi] = out_val;
      assign egr_dat[gi*PORT_WIDTH +: PORT_WIDTH] = out_dat;

      // Egress register and arbiter pointer; contents hold under backpressure.
      always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
          out_val <= 1'b0;
          out_dat <= '0;
          rr      <= '0;
        end else begin
          if (grant) begin
            out_val <= 1'b1;
            out_dat <= head[sel];
            rr      <= (sel == RW'(NP - 1)) ? '0 : sel + 1'b1;
          end else if (egr_rdy[gi]) begin
            out_val <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // An input pops when one output grants it or when its head is dropped.
  always_comb begin
    pop = drop;
    for (int o = 0; o < NP; o++) pop = pop | gnt_mat[o];
  end

  // Sticky drop indication, cleared only by reset.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)     drop_err <= 1'b0;
    else if (|drop) drop_err <= 1'b1;
  end
endmodule

// File: tb/tb_router_mesh.sv
// tb_router_mesh: directed vectors for router_mesh. Main instance is a 4-link
// node at (1,1); a second 2-link node at (0,0) exercises the illegal-port drop.
module tb_router_mesh;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]      ing_val, ing_rdy, egr_val, egr_rdy;
  logic [5*PW-1:0] ing_dat, egr_dat;
  logic            drop_err;
  logic [2:0]      ing_val2, ing_rdy2, egr_val2, egr_rdy2;
  logic [3*PW-1:0] ing_dat2, egr_dat2;
  logic            drop_err2;

  int vectors = 0;
  int miscompares = 0;

  router_mesh #(.NUM_PORTS(4), .PORT_WIDTH(PW), .COORD_W(4), .X_COORD(1),
                .Y_COORD(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .arst(arst), .ing_val(ing_val), .ing_dat(ing_dat),
    .ing_rdy(ing_rdy), .egr_val(egr_val), .egr_dat(egr_dat),
    .egr_rdy(egr_rdy), .drop_err(drop_err));

  router_mesh #(.NUM_PORTS(2), .PORT_WIDTH(PW), .COORD_W(4), .X_COORD(0),
                .Y_COORD(0), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .arst(arst), .ing_val(ing_val2), .ing_dat(ing_dat2),
    .ing_rdy(ing_rdy2), .egr_val(egr_val2), .egr_dat(egr_dat2),
    .egr_rdy(egr_rdy2), .drop_err(drop_err2));

  function automatic logic [PW-1:0] flit(input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [7:0] pay);
    return {dx, dy, pay};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int p, input logic [3:0] dx, input logic [3:0] dy,
                          input logic [7:0] pay, input int o);
    logic [PW-1:0] f;
    f = flit(dx, dy, pay);
    ing_val[p] = 1'b1;
    ing_dat[p*PW +: PW] = f;
    step();
    ing_val[p] = 1'b0;
    check("route_early", 32'(egr_val), 32'd0);
    step();
    check("route_val", 32'(egr_val), 32'(1 << o));
    check("route_dat", 32'(egr_dat[o*PW +: PW]), 32'(f));
    $display("route in=%0d dest=(%0d,%0d) -> out=%0d flit=%h", p, dx, dy, o, egr_dat[o*PW +: PW]);
    step();
    check("route_clr", 32'(egr_val), 32'd0);
  endtask

  initial begin
    int sent;
    int got;
    logic rdy_b;
    logic [PW-1:0] f;

    ing_val = '0; ing_dat = '0; egr_rdy = '1;
    ing_val2 = '0; ing_dat2 = '0; egr_rdy2 = '1;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1 arst = 1'b1;
    check("rst_ing_rdy", 32'(ing_rdy), 32'h1f);
    check("rst_egr_val", 32'(egr_val), 32'd0);
    check("rst_egr_dat", 32'(egr_dat[31:0]), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_ing_rdy2", 32'(ing_rdy2), 32'h7);
    $display("reset released ing_rdy=%h egr_val=%h", ing_rdy, egr_val);

    // Local routing at node (1,1).
    send_one(0, 4'd3, 4'd1, 8'hA5, 1);
    send_one(0, 4'd1, 4'd0, 8'hA6, 4);
    send_one(0, 4'd0, 4'd1, 8'hA7, 2);
    send_one(0, 4'd1, 4'd2, 8'hA8, 3);
    send_one(2, 4'd0, 4'd1, 8'hA9, 2);
    send_one(0, 4'd1, 4'd1, 8'hAA, 0);

    // Round robin: last NI grant came from input 0, so rr[0]=1.
    ing_val = 5'b01110;
    for (int p = 1; p <= 3; p++) ing_dat[p*PW +: PW] = flit(4'd1, 4'd1, {4'(p), 4'd0});
    step();
    for (int p = 1; p <= 3; p++) ing_dat[p*PW +: PW] = flit(4'd1, 4'd1, {4'(p), 4'd1});
    step();
    ing_val = '0;
    for (int k = 0; k < 6; k++) begin
      f = flit(4'd1, 4'd1, {4'(k % 3 + 1), 4'(k / 3)});
      check("rr_val", 32'(egr_val[0]), 32'd1);
      check("rr_dat", 32'(egr_dat[0 +: PW]), 32'(f));
      $display("rr grant %0d flit=%h", k, egr_dat[0 +: PW]);
      step();
    end
    check("rr_idle", 32'(egr_val), 32'd0);

    // Backpressure on E with six flits offered on port 0.
    egr_rdy = 5'b11101;
    sent = 0;
    for (int c = 0; c < 7; c++) begin
      ing_val[0] = 1'b1;
      ing_dat[0 +: PW] = flit(4'd3, 4'd1, 8'(64 + sent));
      rdy_b = ing_rdy[0];
      step();
      if (rdy_b) sent++;
    end
    check("bp_accepts", 32'(sent), 32'd5);
    check("bp_full", 32'(ing_rdy[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_val", 32'(egr_val[1]), 32'd1);
      check("bp_hold_dat", 32'(egr_dat[PW +: PW]), 32'(flit(4'd3, 4'd1, 8'd64)));
      if (c < 2) step();
    end
    egr_rdy = '1;
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (sent < 6) begin
        ing_val[0] = 1'b1;
        ing_dat[0 +: PW] = flit(4'd3, 4'd1, 8'(64 + sent));
      end else begin
        ing_val[0] = 1'b0;
      end
      rdy_b = ing_rdy[0] && ing_val[0];
      if (egr_val[1]) begin
        check("bp_order", 32'(egr_dat[PW +: PW]), 32'(flit(4'd3, 4'd1, 8'(64 + got))));
        $display("bp drain %0d flit=%h", got, egr_dat[PW +: PW]);
        got++;
      end
      step();
      if (rdy_b) sent++;
    end
    ing_val = '0;
    check("bp_count", 32'(got), 32'd6);

    // Illegal port on the 2-link node at (0,0): dest (0,2) needs N.
    ing_val2[0] = 1'b1;
    ing_dat2[0 +: PW] = flit(4'd0, 4'd2, 8'h11);
    step();
    ing_val2[0] = 1'b0;
    step();
    check("drop_flag", 32'(drop_err2), 32'd1);
    check("drop_no_val", 32'(egr_val2), 32'd0);
    step();
    check("drop_sticky", 32'(drop_err2), 32'd1);
    check("drop_no_val2", 32'(egr_val2), 32'd0);
    ing_val2[0] = 1'b1;
    ing_dat2[0 +: PW] = flit(4'd1, 4'd0, 8'h22);
    step();
    ing_val2[0] = 1'b0;
    step();
    check("drop_after_val", 32'(egr_val2), 32'd2);
    check("drop_after_dat", 32'(egr_dat2[PW +: PW]), 32'(flit(4'd1, 4'd0, 8'h22)));
    check("drop_still", 32'(drop_err2), 32'd1);
    check("main_no_drop", 32'(drop_err), 32'd0);
    $display("drop test drop_err2=%0d egr_val2=%b", drop_err2, egr_val2);

    // Reset in the middle of buffered traffic.
    egr_rdy = 5'b11101;
    for (int c = 0; c < 3; c++) begin
      ing_val[0] = 1'b1;
      ing_dat[0 +: PW] = flit(4'd3, 4'd1, 8'(128 + c));
      step();
    end
    ing_val = '0;
    step();
    check("mid_busy", 32'(egr_val[1]), 32'd1);
    arst = 1'b0;
    #1;
    check("mid_async_val", 32'(egr_val), 32'd0);
    check("mid_async_rdy", 32'(ing_rdy), 32'h1f);
    step();
    step();
    arst = 1'b1;
    egr_rdy = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("mid_no_stale", 32'(egr_val), 32'd0);
    end
    check("mid_rdy", 32'(ing_rdy), 32'h1f);
    check("mid_dat", 32'(egr_dat[PW +: PW]), 32'd0);
    check("mid_drop2", 32'(drop_err2), 32'd0);
    $display("mid reset egr_val=%h ing_rdy=%h", egr_val, ing_rdy);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
